hc165_ctrl: RTL and testbench



---
 rtl/hc_io_pkg.sv | 25 ++
 rtl/hc165_ctrl_if.sv | 42 ++++
 rtl/hc165_debounce.sv | 71 +++++++
 rtl/hc165_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hc165_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/hc_io_pkg.sv
// rtl/hc_io_pkg.sv - shared types and constants for the 74HC165/74HC595 board I/O blocks
//
// Holds the scan FSM state enum, the four-phase serial clock phase
// constants and the default chain width / scan period shared by the
// 165 reader and the 595 driver. No ports.
package hc_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SHIFT,
    DONE
  } hc_state_e;

  // Four-phase bit period: data sampled in phase 1, cp rises leaving
  // phase 2, the bit period closes in phase 3.
  localparam logic [1:0] SAMPLE_PH  = 2'd1;
  localparam logic [1:0] CP_RISE_PH = 2'd2;
  localparam logic [1:0] BIT_END_PH = 2'd3;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_SCAN_PERIOD = 50000;

endpackage

// File: rtl/hc165_ctrl_if.sv
// rtl/hc165_ctrl_if.sv - pin and parallel-word bundle of the 74HC165 chain reader
//
// Signals:
//   q7         serial data from the last device of the chain
//   pl_n       parallel load, active low
//   cp         shift clock
//   ce_n       clock enable, active low
//   data_out   last accepted word, MSB is the first bit shifted in
//   data_valid one-cycle strobe when data_out is updated
// Modports: master = reader (hc165_ctrl), slave = board pins / consumer side.
interface hc165_ctrl_if
  import hc_io_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             q7;
  logic             pl_n;
  logic             cp;
  logic             ce_n;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;

  modport master (
    input  q7,
    output pl_n,
    output cp,
    output ce_n,
    output data_out,
    output data_valid
  );

  modport slave (
    output q7,
    input  pl_n,
    input  cp,
    input  ce_n,
    input  data_out,
    input  data_valid
  );

endinterface

// File: rtl/hc165_debounce.sv
// rtl/hc165_debounce.sv - scan-to-scan debounce stage for the 74HC165 reader
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   cap_valid   one-cycle strobe, a complete scan word is on cap_data
//   cap_data    captured word of the finished scan
//   data_out    accepted word (registered)
//   data_valid  one-cycle strobe when data_out changes (registered)
// A word is accepted once DEB_SCANS consecutive scans captured it and it
// differs from the word currently presented.
module hc165_debounce
  import hc_io_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEB_SCANS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_valid,
  input  logic [WIDTH-1:0] cap_data,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid
);

  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_SCANS);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             data_valid_q, data_valid_d;

  always_comb begin
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (cap_valid) begin
      prev_d = cap_data;
      // The count saturates so a long-stable input never wraps back below
      // the threshold.
      if (cap_data != prev_q) begin
        cnt_d = CW'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      if ((cnt_d == CNT_MAX) && (cap_data != data_out_q)) begin
        data_out_d   = cap_data;
        data_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: rtl/hc165_ctrl.sv
// rtl/hc165_ctrl.sv - periodic 74HC165 chain reader with registered parallel output
//
// Ports:
//   sys_clk    system clock (50 MHz)
//   sys_rst_n  asynchronous active-low reset
//   bus        hc165_ctrl_if.master: q7 in; pl_n, cp, ce_n, data_out,
//              data_valid out (all outputs registered)
// Build option: define HC165_DEBOUNCE_EN to route captures through
// hc165_debounce; otherwise every scan updates data_out and pulses
// data_valid.
module hc165_ctrl
  import hc_io_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SCAN_PERIOD = DEF_SCAN_PERIOD,
  parameter int DEB_SCANS   = 3
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  hc165_ctrl_if.master bus
);

  localparam int TW  = $clog2(SCAN_PERIOD);
  localparam int BCW = $clog2(WIDTH);
  localparam logic [TW-1:0]  TMR_LAST = TW'(SCAN_PERIOD - 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(WIDTH - 1);

  if (!((WIDTH == 8) || (WIDTH == 16)) || (SCAN_PERIOD <= 4 * WIDTH + 9) || (DEB_SCANS < 1))
  begin : g_param_check
    $error("hc165_ctrl: unsupported WIDTH / SCAN_PERIOD / DEB_SCANS");
  end

  hc_state_e        state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [1:0]       ph_q, ph_d;
  logic [BCW-1:0]   bc_q, bc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             pl_n_q, pl_n_d;
  logic             cp_q, cp_d;
  logic             ce_n_q, ce_n_d;
  logic             scan_req;

  always_comb begin
    tmr_d    = (tmr_q == TMR_LAST) ? '0 : tmr_q + 1'b1;
    scan_req = (tmr_q == TMR_LAST);
    sync1_d  = bus.q7;
    sync2_d  = sync1_q;

    state_d  = state_q;
    ph_d     = ph_q + 2'd1;
    bc_d     = bc_q;
    shreg_d  = shreg_q;
    pl_n_d   = pl_n_q;
    cp_d     = cp_q;
    ce_n_d   = ce_n_q;

    case (state_q)
      IDLE: begin
        ph_d = '0;
        // A request arriving during a scan is simply not seen here.
        if (scan_req) begin
          state_d = LOAD;
          pl_n_d  = 1'b0;
          cp_d    = 1'b0;
          ce_n_d  = 1'b1;
        end
      end
      LOAD: begin
        if (ph_q == BIT_END_PH) begin
          state_d = SETTLE;
          pl_n_d  = 1'b1;
        end
      end
      SETTLE: begin
        // Gives the loaded MSB time to cross the q7 synchronizer.
        if (ph_q == BIT_END_PH) begin
          state_d = SHIFT;
          ce_n_d  = 1'b0;
          bc_d    = '0;
        end
      end
      SHIFT: begin
        // cp high in phases 3 and 0: rises leaving phase 2, so the next
        // bit is through both sync flops by phase 1 of the next period.
        cp_d = (ph_q == CP_RISE_PH) || (ph_q == BIT_END_PH);
        if (ph_q == SAMPLE_PH) begin
          shreg_d = {shreg_q[WIDTH-2:0], sync2_q};
        end
        if (ph_q == BIT_END_PH) begin
          bc_d = bc_q + 1'b1;
          if (bc_q == BC_LAST) begin
            state_d = DONE;
            cp_d    = 1'b0;
            ce_n_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ph_d    = '0;
        cp_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
        pl_n_d  = 1'b1;
        cp_d    = 1'b0;
        ce_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      ph_q    <= '0;
      bc_q    <= '0;
      shreg_q <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pl_n_q  <= 1'b1;
      cp_q    <= 1'b0;
      ce_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ph_q    <= ph_d;
      bc_q    <= bc_d;
      shreg_q <= shreg_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pl_n_q  <= pl_n_d;
      cp_q    <= cp_d;
      ce_n_q  <= ce_n_d;
    end
  end

  assign bus.pl_n = pl_n_q;
  assign bus.cp   = cp_q;
  assign bus.ce_n = ce_n_q;

`ifdef HC165_DEBOUNCE_EN
  logic [WIDTH-1:0] deb_data;
  logic             deb_valid;

  hc165_debounce #(
    .WIDTH    (WIDTH),
    .DEB_SCANS(DEB_SCANS)
  ) u_debounce (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .cap_valid (state_q == DONE),
    .cap_data  (shreg_q),
    .data_out  (deb_data),
    .data_valid(deb_valid)
  );

  assign bus.data_out   = deb_data;
  assign bus.data_valid = deb_valid;
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;

  always_comb begin
    data_out_d   = (state_q == DONE) ? shreg_q : data_out_q;
    data_valid_d = (state_q == DONE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
`endif

endmodule

// File: tb/tb_hc165_ctrl.sv
// tb/tb_hc165_ctrl.sv - self-checking bench for hc165_ctrl with a 74HC165 chain model
`timescale 1ns/1ps
module tb_hc165_ctrl;

  localparam int W      = 16;
  localparam int SP     = 200;
  localparam int DEB    = 3;
  localparam int CLK_NS = 20;

  logic sys_clk;
  logic sys_rst_n;

  hc165_ctrl_if #(.WIDTH(W)) bus ();

  hc165_ctrl #(
    .WIDTH      (W),
    .SCAN_PERIOD(SP),
    .DEB_SCANS  (DEB)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #(CLK_NS / 2) sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Chain model: parallel load while pl_n is low, shift on a cp rising
  // edge while ce_n is low, q7 is the chain MSB.
  logic [W-1:0] drive_word = '0;
  logic [W-1:0] chain      = '0;
  logic         glitch_en  = 1'b0;
  logic         cp_prev    = 1'b0;

  always @(negedge sys_clk) begin
    if (bus.pl_n === 1'b0) chain = drive_word;
    else if (bus.ce_n === 1'b0 && bus.cp === 1'b1 && cp_prev === 1'b0) chain = {chain[W-2:0], 1'b0};
    cp_prev = bus.cp;
    // Junk on q7 only while cp is low; the level the reader samples is
    // the one present while cp is high.
    if (glitch_en && bus.ce_n === 1'b0 && bus.cp === 1'b0) bus.q7 = 1'($urandom_range(0, 1));
    else bus.q7 = chain[W-1];
  end

  // Reference for the accepted word: history of captured words since reset.
  logic [W-1:0] hist[$];
  logic [W-1:0] exp_out = '0;
  longint       t_prev = 0;
  bit           prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic predict(input logic [W-1:0] w, output bit v);
    hist.push_back(w);
`ifdef HC165_DEBOUNCE_EN
    v = 1'b0;
    if (hist.size() >= DEB && w != exp_out) begin
      v = 1'b1;
      for (int i = 1; i <= DEB; i++) if (hist[hist.size() - i] != w) v = 1'b0;
    end
`else
    v = 1'b1;
`endif
    if (v) exp_out = w;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_pl_n"}, 32'(bus.pl_n), 32'd1);
    check({pfx, "_cp"}, 32'(bus.cp), 32'd0);
    check({pfx, "_ce_n"}, 32'(bus.ce_n), 32'd1);
    check({pfx, "_data_out"}, 32'(bus.data_out), 32'd0);
    check({pfx, "_data_valid"}, 32'(bus.data_valid), 32'd0);
  endtask

  task automatic reset_model();
    hist.delete();
    exp_out    = '0;
    prev_valid = 1'b0;
  endtask

  // One full scan: wait for pl_n to fall, watch the pins for 80 cycles,
  // then compare with the chain/reference model.
  task automatic run_scan(input logic [W-1:0] w, input bit glitch, input int exp_wait);
    int k_wait, vearly, pl_low, rises, last_rise, gap_err, ce_bad, vcnt, vat;
    bit found, v;
    logic cp_last;
    longint t_fall;
    drive_word = w;
    glitch_en  = glitch;
    found = 1'b0; vearly = 0; k_wait = 0;
    for (int i = 1; i <= SP + 10; i++) begin
      @(posedge sys_clk); #1;
      if (bus.data_valid === 1'b1) vearly++;
      if (bus.pl_n === 1'b0) begin
        found = 1'b1; k_wait = i;
        break;
      end
    end
    check("scan_start", 32'(found), 32'd1);
    if (!found) return;
    if (exp_wait >= 0) check("restart_delay", 32'(k_wait), 32'(exp_wait));
    check("idle_valid", 32'(vearly), 32'd0);
    t_fall = $time;
    if (prev_valid) check("scan_period", 32'(t_fall - t_prev), 32'(SP * CLK_NS));
    t_prev = t_fall; prev_valid = 1'b1;

    pl_low = 1; rises = 0; last_rise = 0; gap_err = 0; ce_bad = 0; vcnt = 0; vat = -1;
    cp_last = bus.cp;
    for (int k = 1; k <= 80; k++) begin
      @(posedge sys_clk); #1;
      if (bus.pl_n === 1'b0) pl_low++;
      if (bus.cp === 1'b1 && cp_last === 1'b0) begin
        rises++;
        if (rises > 1 && (k - last_rise) != 4) gap_err++;
        last_rise = k;
        if (bus.ce_n !== 1'b0) ce_bad++;
      end
      cp_last = bus.cp;
      if (bus.data_valid === 1'b1) begin
        vcnt++;
        if (vat < 0) vat = k;
      end
    end
    predict(w, v);
    check("pl_n_low_cycles", 32'(pl_low), 32'd4);
    check("cp_rises", 32'(rises), 32'(W));
    check("cp_spacing", 32'(gap_err), 32'd0);
    check("ce_n_at_cp", 32'(ce_bad), 32'd0);
    check("valid_pulses", 32'(vcnt), v ? 32'd1 : 32'd0);
    if (v) check("valid_latency", 32'(vat), 32'd73);
    check("data_out", 32'(bus.data_out), 32'(exp_out));
  endtask

  // Scan interrupted by reset while bit 7 is being shifted.
  task automatic scan_with_reset(input logic [W-1:0] w);
    bit found;
    drive_word = w;
    glitch_en  = 1'b0;
    found = 1'b0;
    for (int i = 1; i <= SP + 10; i++) begin
      @(posedge sys_clk); #1;
      if (bus.pl_n === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_scan_start", 32'(found), 32'd1);
    repeat (38) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1 check_reset_outputs("midscan_rst");
    repeat (3) @(posedge sys_clk);
    #1 check_reset_outputs("held_rst");
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    reset_model();
  endtask

  logic [W-1:0] deb_seq[6] = '{16'h1234, 16'h1235, 16'h1234, 16'h1234, 16'h1234, 16'h1234};

  initial begin
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 check_reset_outputs("reset");
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    reset_model();

    run_scan(16'hA5C3, 1'b0, SP);
    run_scan(16'h0000, 1'b0, -1);
    run_scan(16'hFFFF, 1'b0, -1);
    for (int i = 0; i < W; i++) run_scan(16'(32'd1 << i), 1'b0, -1);
    for (int i = 0; i < 6; i++) run_scan(16'($urandom), 1'b1, -1);

    run_scan(16'h5AA5, 1'b0, -1);
    scan_with_reset(16'h3C3C);

    for (int i = 0; i < 6; i++) run_scan(deb_seq[i], 1'b0, (i == 0) ? SP : -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
